// File: rtl/serial_pkg.sv
// Shared definitions for the serial link: receiver FSM states and frame constants.
// The transmitter uses FRAME_BITS and IDLE_LEVEL as well.
package serial_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    localparam int   FRAME_BITS = 8;
    localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for an asynchronous serial line; resets to the idle level
// so that leaving reset never looks like a start edge.
module sync2
    import serial_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    // NOTE: reset is synchronous, so it is tested inside the clocked block and never appears in the sensitivity list.
    always_ff @(posedge clk) begin
        if (!reset) begin
            meta_q <= IDLE_LEVEL;
            sync_q <= IDLE_LEVEL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/serial_rx_d.sv
// UART-style receiver: 1 start bit, 8 data bits MSB first, 1 stop bit. Samples at
// mid-bit and presents each good byte with a one-cycle RxRdy strobe.
module serial_rx_d
    import serial_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int CNT_W        = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  serialIn,
    output logic [FRAME_BITS-1:0] out,
    output logic                  RxRdy,
    output logic                  FrameErr
);

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]       BITN_LAST = 4'(FRAME_BITS - 1);

    logic                  rxs;
    logic                  prev_rxs_q, prev_rxs_d;
    rx_state_t             state_q,    state_d;
    logic [CNT_W-1:0]      cnt_q,      cnt_d;
    logic [3:0]            bitn_q,     bitn_d;
    logic [FRAME_BITS-1:0] shreg_q,    shreg_d;
    logic [FRAME_BITS-1:0] out_q,      out_d;
    logic                  rdy_q,      rdy_d;
    logic                  ferr_q,     ferr_d;

    sync2 u_sync_rx (
        .clk   (clk),
        .reset (reset),
        .d     (serialIn),
        .q     (rxs)
    );

    // NOTE: every always_comb output gets a default first, so no path leaves a value unassigned and no latch is inferred.
    always_comb begin
        prev_rxs_d = rxs;
        state_d    = state_q;
        cnt_d      = cnt_q;
        bitn_d     = bitn_q;
        shreg_d    = shreg_q;
        out_d      = out_q;
        rdy_d      = 1'b0;
        ferr_d     = 1'b0;

        case (state_q)
            IDLE: begin
                // A falling edge is required, so a held-low break never restarts a frame.
                if (prev_rxs_q == IDLE_LEVEL && rxs != IDLE_LEVEL) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    bitn_d  = '0;
                    state_d = (rxs != IDLE_LEVEL) ? DATA : IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt_q == BIT_LAST) begin
                    shreg_d = {shreg_q[FRAME_BITS-2:0], rxs};
                    bitn_d  = bitn_q + 4'd1;
                    cnt_d   = '0;
                    if (bitn_q == BITN_LAST) begin
                        state_d = STOP;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STOP: begin
                // Returning to IDLE at the stop mid-point lets a back-to-back start edge be seen.
                if (cnt_q == BIT_LAST) begin
                    if (rxs == IDLE_LEVEL) begin
                        out_d = shreg_q;
                        rdy_d = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            prev_rxs_q <= IDLE_LEVEL;
            state_q    <= IDLE;
            cnt_q      <= '0;
            bitn_q     <= '0;
            shreg_q    <= '0;
            out_q      <= '0;
            rdy_q      <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            prev_rxs_q <= prev_rxs_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bitn_q     <= bitn_d;
            shreg_q    <= shreg_d;
            out_q      <= out_d;
            rdy_q      <= rdy_d;
            ferr_q     <= ferr_d;
        end
    end

    assign out      = out_q;
    assign RxRdy    = rdy_q;
    assign FrameErr = ferr_q;

endmodule

// File: tb/tb_serial_rx_d.sv
// Scoreboard bench for serial_rx_d: a 4-clk/bit instance for most scenarios and a
// 16-clk/bit instance for the skewed-edge frame.
module tb_serial_rx_d;
    import serial_pkg::*;

    localparam int N4  = 4;
    localparam int N16 = 16;

    typedef struct packed {
        logic       is_err;
        logic [7:0] data;
    } exp_t;

    logic       clk    = 1'b0;
    logic       reset  = 1'b0;
    logic       line4  = 1'b1;
    logic       line16 = 1'b1;
    logic [7:0] out4, out16;
    logic       rdy4, err4, rdy16, err16;

    exp_t q4[$];
    exp_t q16[$];
    exp_t e4, e16;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int rdy_cnt4 = 0, err_cnt4 = 0, rdy_cnt16 = 0, err_cnt16 = 0;
    int last_rdy_cyc4 = -1;
    int start_cyc, base_rdy, base_err;
    logic prev_rdy4 = 1'b0, prev_err4 = 1'b0;
    int skew[11] = '{0, 3, -3, 2, -2, 3, -3, 1, -1, 3, 0};
    logic [9:0] frame16;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_rx_d #(.CLKS_PER_BIT(N4), .CNT_W(8)) dut4 (
        .clk      (clk),
        .reset    (reset),
        .serialIn (line4),
        .out      (out4),
        .RxRdy    (rdy4),
        .FrameErr (err4)
    );

    serial_rx_d #(.CLKS_PER_BIT(N16), .CNT_W(8)) dut16 (
        .clk      (clk),
        .reset    (reset),
        .serialIn (line16),
        .out      (out16),
        .RxRdy    (rdy16),
        .FrameErr (err16)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Monitor for the N=4 instance: each strobe must match the oldest expected entry.
    always @(negedge clk) begin
        if (reset) begin
            if (rdy4 || err4) begin
                check("exclusive4", 32'(rdy4 && err4), 0);
                check("pending4", 32'(q4.size() > 0), 1);
            end
            if (rdy4) check("rdy4_one_cycle", 32'(prev_rdy4), 0);
            if (err4) check("err4_one_cycle", 32'(prev_err4), 0);
            if ((rdy4 || err4) && q4.size() > 0) begin
                e4 = q4.pop_front();
                check("kind4", 32'(err4), 32'(e4.is_err));
                check("out4", 32'(out4), 32'(e4.data));
            end
            if (rdy4) begin
                rdy_cnt4++;
                last_rdy_cyc4 = cyc;
            end
            if (err4) err_cnt4++;
        end
        prev_rdy4 = rdy4;
        prev_err4 = err4;
    end

    always @(negedge clk) begin
        if (reset && (rdy16 || err16)) begin
            check("pending16", 32'(q16.size() > 0), 1);
            if (q16.size() > 0) begin
                e16 = q16.pop_front();
                check("kind16", 32'(err16), 32'(e16.is_err));
                check("out16", 32'(out16), 32'(e16.data));
            end
            if (rdy16) rdy_cnt16++;
            if (err16) err_cnt16++;
        end
    end

    task automatic drive4(input logic v, input int n);
        line4 = v;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send4(input logic [7:0] b, input logic stop_v);
        drive4(1'b0, N4);
        for (int i = 7; i >= 0; i--) drive4(b[i], N4);
        drive4(stop_v, N4);
    endtask

    task automatic wait_drain4(input int budget);
        int k = 0;
        while (q4.size() > 0 && k < budget) begin
            @(posedge clk); #1;
            k++;
        end
        check("drain4", q4.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        check("rst_out", 32'(out4), 0);
        check("rst_rdy", 32'(rdy4), 0);
        check("rst_ferr", 32'(err4), 0);
        reset = 1'b1;
        drive4(1'b1, 4);

        // Single good frame with latency measurement
        base_rdy = rdy_cnt4; base_err = err_cnt4;
        q4.push_back({1'b0, 8'hA5});
        start_cyc = cyc + 1;
        send4(8'hA5, 1'b1);
        drive4(1'b1, 4);
        wait_drain4(20);
        check("lat_a5", last_rdy_cyc4, start_cyc + 2 + N4 / 2 + 9 * N4);
        check("out_a5", 32'(out4), 32'h0000_00A5);
        check("rdy_a5", rdy_cnt4 - base_rdy, 1);
        check("ferr_a5", err_cnt4 - base_err, 0);

        // Bad stop bit, then a long break: one FrameErr, out keeps A5
        base_rdy = rdy_cnt4; base_err = err_cnt4;
        q4.push_back({1'b1, 8'hA5});
        send4(8'h3C, 1'b0);
        drive4(1'b0, 40);
        drive4(1'b1, 8);
        wait_drain4(20);
        check("ferr_cnt", err_cnt4 - base_err, 1);
        check("ferr_no_rdy", rdy_cnt4 - base_rdy, 0);
        check("ferr_out_hold", 32'(out4), 32'h0000_00A5);

        // Back-to-back frames with no idle gap
        base_rdy = rdy_cnt4; base_err = err_cnt4;
        q4.push_back({1'b0, 8'h00});
        send4(8'h00, 1'b1);
        q4.push_back({1'b0, 8'hFF});
        send4(8'hFF, 1'b1);
        drive4(1'b1, 4);
        wait_drain4(20);
        check("b2b_rdy", rdy_cnt4 - base_rdy, 2);
        check("b2b_ferr", err_cnt4 - base_err, 0);
        check("b2b_out", 32'(out4), 32'h0000_00FF);

        // One-clock glitch is rejected, following frame is received
        base_rdy = rdy_cnt4; base_err = err_cnt4;
        drive4(1'b0, 1);
        drive4(1'b1, 20);
        check("glitch_state", 32'(dut4.state_q), 32'(IDLE));
        check("glitch_strobes", (rdy_cnt4 - base_rdy) + (err_cnt4 - base_err), 0);
        q4.push_back({1'b0, 8'h3C});
        send4(8'h3C, 1'b1);
        drive4(1'b1, 4);
        wait_drain4(20);
        check("glitch_next_out", 32'(out4), 32'h0000_003C);

        // Reset mid-frame after four data bits of F0
        base_rdy = rdy_cnt4; base_err = err_cnt4;
        drive4(1'b0, N4);
        for (int i = 0; i < 4; i++) drive4(1'b1, N4);
        reset = 1'b0;
        line4 = 1'b1;
        @(posedge clk); #1;
        check("midrst_out", 32'(out4), 0);
        check("midrst_rdy", 32'(rdy4), 0);
        check("midrst_ferr", 32'(err4), 0);
        reset = 1'b1;
        drive4(1'b1, 20);
        check("midrst_strobes", (rdy_cnt4 - base_rdy) + (err_cnt4 - base_err), 0);
        q4.push_back({1'b0, 8'h5A});
        send4(8'h5A, 1'b1);
        drive4(1'b1, 4);
        wait_drain4(20);
        check("midrst_next_out", 32'(out4), 32'h0000_005A);

        // N=16 frame with every bit edge skewed by up to +-3 clocks
        base_rdy = rdy_cnt16; base_err = err_cnt16;
        q16.push_back({1'b0, 8'h81});
        frame16 = {1'b0, 8'h81, 1'b1};
        for (int b = 0; b < 10; b++) begin
            line16 = frame16[9 - b];
            repeat (N16 + skew[b + 1] - skew[b]) begin @(posedge clk); #1; end
        end
        line16 = 1'b1;
        for (int k = 0; k < 40 && q16.size() > 0; k++) begin @(posedge clk); #1; end
        check("drain16", q16.size(), 0);
        check("skew_out", 32'(out16), 32'h0000_0081);
        check("skew_rdy", rdy_cnt16 - base_rdy, 1);
        check("skew_ferr", err_cnt16 - base_err, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
